// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared state encoding and default widths for sum_accumulator
package acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } acc_state_t;

  localparam int IN_W_DEF  = 5;
  localparam int ACC_W_DEF = 8;

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - signed add with overflow flag; ACC_SATURATE_EN clamps, otherwise wraps
module sat_add #(
  parameter int ACC_W = 8
) (
  input  logic signed [ACC_W-1:0] a_i,
  input  logic signed [ACC_W-1:0] b_i,
  output logic signed [ACC_W-1:0] sum_o,
  output logic                    ovf_o
);

  localparam logic [ACC_W-1:0] MAX_VAL = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_VAL = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] wide;

  // One guard bit: the result left the signed range when the top two bits disagree.
  always_comb begin
    wide  = {a_i[ACC_W-1], a_i} + {b_i[ACC_W-1], b_i};
    ovf_o = wide[ACC_W] ^ wide[ACC_W-1];
`ifdef ACC_SATURATE_EN
    if (ovf_o) begin
      sum_o = wide[ACC_W] ? MIN_VAL : MAX_VAL;
    end else begin
      sum_o = wide[ACC_W-1:0];
    end
`else
    sum_o = wide[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - frames FRAME_LEN signed samples into a held total; ACC_SATURATE_EN selects clamping
module sum_accumulator
  import acc_pkg::*;
#(
  parameter int IN_W      = IN_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int FRAME_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  input  logic             out_ready,
  output logic             ovf
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  acc_state_t        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              ovf_q, ovf_d;

  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    add_ovf;
  logic                    accept;

  assign sample_ext = ACC_W'($signed(in_data));
  assign in_ready   = (state_q != HOLD);
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign ovf        = ovf_q;

  // acc is zero in IDLE, so the same adder serves the first sample of a frame.
  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a_i   (acc_q),
    .b_i   (sample_ext),
    .sum_o (sum),
    .ovf_o (add_ovf)
  );

  // Next-state: clear dominates, then frame collection or result handoff.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    if (clear) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      ovf_d       = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            ovf_d = ovf_q | add_ovf;
            if (cnt_q == LAST_CNT) begin
              out_data_d  = sum;
              out_valid_d = 1'b1;
              state_d     = HOLD;
            end else begin
              acc_d   = sum;
              cnt_d   = cnt_q + CNT_W'(1);
              state_d = ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            ovf_d       = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - three configurations against a frame-level reference model
module tb_sum_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       clr[3];
  logic       vin[3];
  logic       ordy[3];
  logic [4:0] din[3];
  logic       rdy[3];
  logic       ov[3];
  logic       of[3];
  logic [7:0] od0;
  logic [5:0] od1;
  logic [7:0] od2;
  int         odata[3];

  int checks   = 0;
  int failures = 0;

  sum_accumulator #(.IN_W(5), .ACC_W(8), .FRAME_LEN(4)) u0 (
    .clk(clk), .reset(reset), .clear(clr[0]), .in_valid(vin[0]), .in_data(din[0]),
    .in_ready(rdy[0]), .out_valid(ov[0]), .out_data(od0), .out_ready(ordy[0]), .ovf(of[0]));
  sum_accumulator #(.IN_W(5), .ACC_W(6), .FRAME_LEN(4)) u1 (
    .clk(clk), .reset(reset), .clear(clr[1]), .in_valid(vin[1]), .in_data(din[1]),
    .in_ready(rdy[1]), .out_valid(ov[1]), .out_data(od1), .out_ready(ordy[1]), .ovf(of[1]));
  sum_accumulator #(.IN_W(5), .ACC_W(8), .FRAME_LEN(1)) u2 (
    .clk(clk), .reset(reset), .clear(clr[2]), .in_valid(vin[2]), .in_data(din[2]),
    .in_ready(rdy[2]), .out_valid(ov[2]), .out_data(od2), .out_ready(ordy[2]), .ovf(of[2]));

  always_comb begin
    odata[0] = int'($signed(od0));
    odata[1] = int'($signed(od1));
    odata[2] = int'($signed(od2));
  end

  function automatic int aw_of(int k);
    return (k == 1) ? 6 : 8;
  endfunction

  function automatic int fl_of(int k);
    return (k == 2) ? 1 : 4;
  endfunction

  // Frame total from plain integer arithmetic over the collected samples.
  function automatic void frame_total(input int k, input int smp[4], output int tot, output bit o);
    int hi, lo, m, s;
    hi = (1 << (aw_of(k) - 1)) - 1;
    lo = -(1 << (aw_of(k) - 1));
    m  = 1 << aw_of(k);
    s  = 0;
    o  = 1'b0;
    for (int i = 0; i < fl_of(k); i++) begin
      s = s + smp[i];
      if (s > hi || s < lo) begin
        o = 1'b1;
`ifdef ACC_SATURATE_EN
        s = (s > hi) ? hi : lo;
`else
        s = ((s % m) + m) % m;
        if (s > hi) s = s - m;
`endif
      end
    end
    tot = s;
  endfunction

  int m_cnt[3];
  int m_smp[3][4];
  bit m_hold[3];
  int m_data[3];
  bit m_ovf[3];
  int frames[3] = '{0, 0, 0};

  // Reference model: which samples a frame holds and what it must present.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        m_cnt[k]  <= 0;
        m_hold[k] <= 1'b0;
        m_data[k] <= 0;
        m_ovf[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        automatic int c = m_cnt[k];
        automatic int tmp[4] = m_smp[k];
        automatic int tot = 0;
        automatic bit o = 1'b0;
        if (clr[k]) begin
          m_cnt[k]  <= 0;
          m_hold[k] <= 1'b0;
          m_ovf[k]  <= 1'b0;
        end else if (m_hold[k]) begin
          if (ordy[k]) begin
            m_hold[k] <= 1'b0;
            m_ovf[k]  <= 1'b0;
          end
        end else if (vin[k]) begin
          tmp[c] = $signed(din[k]);
          if (c + 1 == fl_of(k)) begin
            frame_total(k, tmp, tot, o);
            m_data[k] <= tot;
            m_ovf[k]  <= o;
            m_hold[k] <= 1'b1;
            m_cnt[k]  <= 0;
            frames[k] <= frames[k] + 1;
          end else begin
            m_smp[k] <= tmp;
            m_cnt[k] <= c + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0d expected=%0d", nm, k, act, exp);
    end
  endtask

  // Continuous comparison of all three DUTs against the model.
  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        chk("in_ready", k, int'(rdy[k]), int'(!m_hold[k]));
        chk("out_valid", k, int'(ov[k]), int'(m_hold[k]));
        chk("out_data", k, odata[k], m_data[k]);
        if (m_hold[k]) chk("ovf", k, int'(of[k]), int'(m_ovf[k]));
      end
    end
  end

  task automatic send(input int k, input int x);
    int n;
    vin[k] = 1'b1;
    din[k] = 5'(x);
    for (n = 0; n < 20; n++) begin
      if (rdy[k]) break;
      @(negedge clk);
    end
    if (n == 20) chk("send_timeout", k, 0, 1);
    @(negedge clk);
    vin[k] = 1'b0;
  endtask

  task automatic handshake(input int k);
    ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
  endtask

  initial begin
    int base[3];
    int cyc;
    for (int k = 0; k < 3; k++) begin
      clr[k] = 1'b0; vin[k] = 1'b0; ordy[k] = 1'b0; din[k] = '0;
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 0, int'(rdy[0]), 1);
    chk("reset_out_valid", 0, int'(ov[0]), 0);
    chk("reset_out_data", 0, odata[0], 0);
    chk("reset_ovf", 0, int'(of[0]), 0);

    // reset in the middle of a frame
    send(0, 14);
    send(0, -16);
    #2 reset = 1'b0;
    #1;
    chk("midreset_out_valid", 0, int'(ov[0]), 0);
    chk("midreset_out_data", 0, odata[0], 0);
    chk("midreset_ovf", 0, int'(of[0]), 0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("midreset_in_ready", 0, int'(rdy[0]), 1);

    // basic back-to-back frame
    send(0, 14); send(0, -16); send(0, 7); send(0, -1);
    chk("basic_out_valid", 0, int'(ov[0]), 1);
    chk("basic_out_data", 0, odata[0], 4);
    chk("basic_ovf", 0, int'(of[0]), 0);
    chk("basic_in_ready", 0, int'(rdy[0]), 0);
    handshake(0);

    // gaps on input, backpressure on output
    send(0, 14); repeat (2) @(negedge clk);
    send(0, -16); @(negedge clk);
    send(0, 7); repeat (3) @(negedge clk);
    send(0, -1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_out_data", 0, odata[0], 4);
      chk("bp_in_ready", 0, int'(rdy[0]), 0);
    end
    handshake(0);
    chk("bp_out_valid_after", 0, int'(ov[0]), 0);
    chk("bp_in_ready_after", 0, int'(rdy[0]), 1);

    // overflow in the 6-bit accumulator
    repeat (4) send(1, -16);
    chk("ovf_flag", 1, int'(of[1]), 1);
`ifdef ACC_SATURATE_EN
    chk("ovf_out_data", 1, odata[1], -32);
`else
    chk("ovf_out_data", 1, odata[1], 0);
`endif
    handshake(1);

    // clear drops a partial frame and the coincident sample
    send(0, 15); send(0, 15);
    vin[0] = 1'b1; din[0] = 5'd15; clr[0] = 1'b1;
    @(negedge clk);
    vin[0] = 1'b0; clr[0] = 1'b0;
    chk("clear_in_ready", 0, int'(rdy[0]), 1);
    chk("clear_out_valid", 0, int'(ov[0]), 0);
    repeat (4) send(0, 1);
    chk("clear_next_out_data", 0, odata[0], 4);
    chk("clear_next_out_valid", 0, int'(ov[0]), 1);
    handshake(0);

    // single-sample frames
    send(2, -16);
    chk("fl1_out_valid", 2, int'(ov[2]), 1);
    chk("fl1_out_data", 2, odata[2], -16);
    handshake(2);

    // randomized traffic until every configuration has seen 50 more frames
    for (int k = 0; k < 3; k++) base[k] = frames[k];
    cyc = 0;
    while ((frames[0] < base[0] + 50 || frames[1] < base[1] + 50 ||
            frames[2] < base[2] + 50) && cyc < 20000) begin
      for (int k = 0; k < 3; k++) begin
        vin[k]  = ($urandom_range(0, 3) != 0);
        din[k]  = 5'($urandom);
        ordy[k] = $urandom_range(0, 1) == 1;
        clr[k]  = ($urandom_range(0, 63) == 0);
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 20000) chk("random_frame_budget", 0, cyc, 0);
    for (int k = 0; k < 3; k++) begin
      vin[k] = 1'b0; ordy[k] = 1'b0; clr[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
Downstream stage of the registered signed 4-bit adder. Consumes its 5-bit signed sum stream through a valid/ready handshake. Accumulates FRAME_LEN accepted samples into a signed ACC_W-bit total and presents the frame result on a held output handshake. Flags overflow per frame.

Parameters:
IN_W, 5, width of signed input sample (adder sum width)
ACC_W, 8, width of signed accumulator and result
FRAME_LEN, 4, samples per frame; legal range 1..255; internal counter width derived via $clog2(FRAME_LEN+1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
clear  in  1  synchronous abort: discard partial frame and pending result
in_valid  in  1  input sample valid
in_data  in  IN_W  signed sample (adder output C)
in_ready  out  1  block can accept a sample this cycle
out_valid  out  1  frame result valid
out_data  out  ACC_W  signed frame total
out_ready  in  1  consumer accepts result
ovf  out  1  overflow occurred in the frame now presented

Behaviour:
- Reset (reset=0, async): state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, ovf=0. in_ready is 1 after release.
- States:
  - IDLE: acc=0, cnt=0. in_ready=1.
  - ACCUM: collecting samples. in_ready=1.
  - HOLD: result presented. in_ready=0.
- A sample is accepted when in_valid && in_ready. in_data is sign-extended to ACC_W. The addition uses ACC_W+1 bits for overflow detection.
- IDLE, on accept:
  - If FRAME_LEN==1: out_data <= sample, out_valid <= 1, go to HOLD.
  - Otherwise: acc <= sample, cnt <= 1, go to ACCUM.
- ACCUM, on accept:
  - If cnt==FRAME_LEN-1: out_data <= acc+sample, out_valid <= 1, go to HOLD.
  - Otherwise: acc <= acc+sample, cnt <= cnt+1.
- ACCUM with no accept: hold all state. Gaps in in_valid are allowed.
- Latency: result is visible the cycle after the last sample is accepted.
- HOLD:
  - out_data, ovf and out_valid are stable until out_valid && out_ready.
  - On that handshake: out_valid <= 0, ovf <= 0, acc <= 0, cnt <= 0, go to IDLE.
  - No input is accepted during HOLD, including the handshake cycle.
- ovf is sticky within a frame. It is set when any partial or final sum leaves the [-2^(ACC_W-1), 2^(ACC_W-1)-1] range, and is presented with the result.
- clear=1 overrides every state:
  - Go to IDLE; acc, cnt, out_valid and ovf go to 0; out_data holds its last value.
  - A sample presented in the same cycle is discarded.
- reset asserted mid-frame or in HOLD: immediate return to reset values. No partial result is emitted.
- in_data is don't-care when in_valid=0. out_ready is ignored outside HOLD.

Optional Feature:
Macro ACC_SATURATE_EN.
- Defined: every out-of-range sum clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1). Later samples add to the clamped value.
- Undefined: sums wrap modulo 2^ACC_W (two's complement truncation).
- ovf is set identically in both builds.

Decomposition:
- Package acc_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCUM, HOLD} acc_state_t
  - localparam IN_W_DEF = 5
  - localparam ACC_W_DEF = 8
- One sub-module, sat_add: combinational ACC_W+1 add with overflow flag, plus clamp or wrap selected by ACC_SATURATE_EN. Instantiated once.

Test Plan:
- Reset mid-frame: accept 14,-16, drop reset to 0 -> out_valid=0, out_data=0, ovf=0, in_ready=1 after release.
- Basic frame (ACC_W=8, FRAME_LEN=4): send 14,-16,7,-1 back-to-back -> out_valid=1 one cycle after 4th accept, out_data=4, ovf=0, in_ready=0 until handshake.
- Backpressure and gaps: same frame with in_valid idle cycles, out_ready held 0 for 3 cycles -> out_data stays 4; one cycle after out_ready=1, out_valid=0 and in_ready=1.
- Overflow (ACC_W=6, FRAME_LEN=4): send -16 four times -> ovf=1. With ACC_SATURATE_EN: out_data=-32. Without: out_data=0.
- Clear: accept 15,15, assert clear with in_valid=1, in_data=15 -> IDLE, sample dropped; the next frame 1,1,1,1 yields 4.
- Boundaries:
  - FRAME_LEN=1, send -16: out_valid next cycle, out_data=-16.
  - Then 50 random sample frames against a reference model; zero mismatches required.
